// File: rtl/procyon_lib_pkg.sv
// Shared Procyon library definitions. PCYN_C2I(n) is the bit width needed
// to encode n distinct values (never less than one bit).
`ifndef PCYN_C2I
`define PCYN_C2I(x) (((x) > 1) ? $clog2(x) : 1)
`endif

package procyon_lib_pkg;
endpackage

// File: rtl/procyon_fifo_cnt_ctrl.sv
// FIFO bookkeeping: head/tail/count registers, accept rules, flush and the
// registered-count status flags. Depth need not be a power of two.
module procyon_fifo_cnt_ctrl
   import procyon_lib_pkg::*;
#(
   parameter int OPTN_FIFO_DEPTH    = 8,
   parameter int OPTN_AFULL_THRESH  = OPTN_FIFO_DEPTH-1,
   parameter int OPTN_AEMPTY_THRESH = 1,
   parameter int FIFO_IDX_WIDTH     = `PCYN_C2I(OPTN_FIFO_DEPTH),
   parameter int FIFO_CNT_WIDTH     = `PCYN_C2I(OPTN_FIFO_DEPTH+1)
) (
   input  logic                      clk,
   input  logic                      n_rst,
   input  logic                      i_flush,
   input  logic                      i_push,
   input  logic                      i_pop,
   output logic [FIFO_IDX_WIDTH-1:0] o_head,
   output logic [FIFO_IDX_WIDTH-1:0] o_tail,
   output logic [FIFO_CNT_WIDTH-1:0] o_count,
   output logic                      o_push_ok,
   output logic                      o_pop_ok,
   output logic                      o_full,
   output logic                      o_empty,
   output logic                      o_afull,
   output logic                      o_aempty
);

   localparam logic [FIFO_CNT_WIDTH-1:0] DEPTH_C  = FIFO_CNT_WIDTH'(OPTN_FIFO_DEPTH);
   localparam logic [FIFO_CNT_WIDTH-1:0] AFULL_C  = FIFO_CNT_WIDTH'(OPTN_AFULL_THRESH);
   localparam logic [FIFO_CNT_WIDTH-1:0] AEMPTY_C = FIFO_CNT_WIDTH'(OPTN_AEMPTY_THRESH);
   localparam logic [FIFO_IDX_WIDTH-1:0] LAST_IDX = FIFO_IDX_WIDTH'(OPTN_FIFO_DEPTH-1);

   if ((OPTN_FIFO_DEPTH < 2) || (OPTN_AEMPTY_THRESH < 0) ||
       (OPTN_AEMPTY_THRESH >= OPTN_AFULL_THRESH) || (OPTN_AFULL_THRESH > OPTN_FIFO_DEPTH)) begin : g_bad_params
      $error("procyon_fifo_cnt_ctrl: illegal depth/threshold parameters");
   end

   logic [FIFO_IDX_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
   logic [FIFO_CNT_WIDTH-1:0] count_q, count_d;
   logic                      push_ok, pop_ok;

   // Explicit wrap so non-power-of-two depths index correctly.
   function automatic logic [FIFO_IDX_WIDTH-1:0] next_ptr(input logic [FIFO_IDX_WIDTH-1:0] ptr);
      return (ptr == LAST_IDX) ? '0 : ptr + FIFO_IDX_WIDTH'(1);
   endfunction

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      pop_ok  = ~i_flush & i_pop & (count_q != '0);
      push_ok = ~i_flush & i_push & ((count_q != DEPTH_C) | pop_ok);
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (i_flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push_ok) tail_d = next_ptr(tail_q);
         if (pop_ok)  head_d = next_ptr(head_q);
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + FIFO_CNT_WIDTH'(1);
            2'b01:   count_d = count_q - FIFO_CNT_WIDTH'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: blocking (=) in always_comb, non-blocking (<=) in always_ff; mixing them races in simulation.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign o_head    = head_q;
   assign o_tail    = tail_q;
   assign o_count   = count_q;
   assign o_push_ok = push_ok;
   assign o_pop_ok  = pop_ok;
   assign o_full    = (count_q == DEPTH_C);
   assign o_empty   = (count_q == '0);
   assign o_afull   = (count_q >= AFULL_C);
   assign o_aempty  = (count_q <= AEMPTY_C);

endmodule

// File: rtl/procyon_sync_fifo_ctrl_ext.sv
// Synchronous FIFO with standard (registered) or first-word-fall-through
// read mode, occupancy/threshold flags and sticky overflow/underflow errors.
module procyon_sync_fifo_ctrl_ext
   import procyon_lib_pkg::*;
#(
   parameter int OPTN_DATA_WIDTH    = 8,
   parameter int OPTN_FIFO_DEPTH    = 8,
   parameter int OPTN_FWFT          = 0,
   parameter int OPTN_AFULL_THRESH  = OPTN_FIFO_DEPTH-1,
   parameter int OPTN_AEMPTY_THRESH = 1
) (
   input  logic                                      clk,
   input  logic                                      n_rst,
   input  logic                                      i_flush,
   input  logic                                      i_fifo_ack,
   output logic [OPTN_DATA_WIDTH-1:0]                o_fifo_data,
   output logic                                      o_fifo_valid,
   output logic                                      o_fifo_empty,
   input  logic                                      i_fifo_we,
   input  logic [OPTN_DATA_WIDTH-1:0]                i_fifo_data,
   output logic                                      o_fifo_full,
   output logic [`PCYN_C2I(OPTN_FIFO_DEPTH+1)-1:0]   o_fifo_count,
   output logic                                      o_fifo_afull,
   output logic                                      o_fifo_aempty,
   output logic                                      o_fifo_overflow,
   output logic                                      o_fifo_underflow
);

   localparam int FIFO_IDX_WIDTH = `PCYN_C2I(OPTN_FIFO_DEPTH);
   localparam int FIFO_CNT_WIDTH = `PCYN_C2I(OPTN_FIFO_DEPTH+1);

   logic [OPTN_DATA_WIDTH-1:0] mem_q [OPTN_FIFO_DEPTH];
   logic [FIFO_IDX_WIDTH-1:0]  head, tail;
   logic                       push_ok, pop_ok;
   logic                       overflow_q, overflow_d, underflow_q, underflow_d;

   procyon_fifo_cnt_ctrl #(
      .OPTN_FIFO_DEPTH    (OPTN_FIFO_DEPTH),
      .OPTN_AFULL_THRESH  (OPTN_AFULL_THRESH),
      .OPTN_AEMPTY_THRESH (OPTN_AEMPTY_THRESH),
      .FIFO_IDX_WIDTH     (FIFO_IDX_WIDTH),
      .FIFO_CNT_WIDTH     (FIFO_CNT_WIDTH)
   ) u_cnt_ctrl (
      .clk       (clk),
      .n_rst     (n_rst),
      .i_flush   (i_flush),
      .i_push    (i_fifo_we),
      .i_pop     (i_fifo_ack),
      .o_head    (head),
      .o_tail    (tail),
      .o_count   (o_fifo_count),
      .o_push_ok (push_ok),
      .o_pop_ok  (pop_ok),
      .o_full    (o_fifo_full),
      .o_empty   (o_fifo_empty),
      .o_afull   (o_fifo_afull),
      .o_aempty  (o_fifo_aempty)
   );

   // NOTE: storage has no reset; validity is tracked by the pointers and count, so it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[tail] <= i_fifo_data;
   end

   always_comb begin
      overflow_d  = overflow_q  | (i_fifo_we  & ~push_ok);
      underflow_d = underflow_q | (i_fifo_ack & ~pop_ok);
      if (i_flush) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign o_fifo_overflow  = overflow_q;
   assign o_fifo_underflow = underflow_q;

   if (OPTN_FWFT != 0) begin : g_fwft
      assign o_fifo_data  = mem_q[head];
      assign o_fifo_valid = ~o_fifo_empty;
   end else begin : g_std
      logic [OPTN_DATA_WIDTH-1:0] rdata_q, rdata_d;
      logic                       rvalid_q, rvalid_d;

      // A full push+pop reads the old head: the memory write above is non-blocking.
      always_comb begin
         rdata_d  = pop_ok ? mem_q[head] : rdata_q;
         rvalid_d = pop_ok;
      end

      always_ff @(posedge clk or negedge n_rst) begin
         if (!n_rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
         end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
         end
      end

      assign o_fifo_data  = rdata_q;
      assign o_fifo_valid = rvalid_q;
   end

endmodule

// File: tb/tb_procyon_sync_fifo_ctrl_ext.sv
// Directed bench: standard DEPTH=4, FWFT DEPTH=4 and standard DEPTH=3 instances.
// Status vectors are {empty, full, afull, aempty, valid, overflow, underflow}.
module tb_procyon_sync_fifo_ctrl_ext;

   logic clk = 1'b0;
   logic n_rst = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic       s_flush = 1'b0, s_ack = 1'b0, s_we = 1'b0;
   logic [7:0] s_wdata = '0, s_rdata;
   logic       s_valid, s_empty, s_full, s_afull, s_aempty, s_ovf, s_udf;
   logic [2:0] s_count;

   logic       f_flush = 1'b0, f_ack = 1'b0, f_we = 1'b0;
   logic [7:0] f_wdata = '0, f_rdata;
   logic       f_valid, f_empty, f_full, f_afull, f_aempty, f_ovf, f_udf;
   logic [2:0] f_count;

   logic       w_flush = 1'b0, w_ack = 1'b0, w_we = 1'b0;
   logic [7:0] w_wdata = '0, w_rdata;
   logic       w_valid, w_empty, w_full, w_afull, w_aempty, w_ovf, w_udf;
   logic [1:0] w_count;

   procyon_sync_fifo_ctrl_ext #(.OPTN_DATA_WIDTH(8), .OPTN_FIFO_DEPTH(4), .OPTN_FWFT(0)) u_std (
      .clk(clk), .n_rst(n_rst), .i_flush(s_flush), .i_fifo_ack(s_ack), .o_fifo_data(s_rdata),
      .o_fifo_valid(s_valid), .o_fifo_empty(s_empty), .i_fifo_we(s_we), .i_fifo_data(s_wdata),
      .o_fifo_full(s_full), .o_fifo_count(s_count), .o_fifo_afull(s_afull), .o_fifo_aempty(s_aempty),
      .o_fifo_overflow(s_ovf), .o_fifo_underflow(s_udf));

   procyon_sync_fifo_ctrl_ext #(.OPTN_DATA_WIDTH(8), .OPTN_FIFO_DEPTH(4), .OPTN_FWFT(1)) u_fwft (
      .clk(clk), .n_rst(n_rst), .i_flush(f_flush), .i_fifo_ack(f_ack), .o_fifo_data(f_rdata),
      .o_fifo_valid(f_valid), .o_fifo_empty(f_empty), .i_fifo_we(f_we), .i_fifo_data(f_wdata),
      .o_fifo_full(f_full), .o_fifo_count(f_count), .o_fifo_afull(f_afull), .o_fifo_aempty(f_aempty),
      .o_fifo_overflow(f_ovf), .o_fifo_underflow(f_udf));

   procyon_sync_fifo_ctrl_ext #(.OPTN_DATA_WIDTH(8), .OPTN_FIFO_DEPTH(3), .OPTN_FWFT(0)) u_wrap (
      .clk(clk), .n_rst(n_rst), .i_flush(w_flush), .i_fifo_ack(w_ack), .o_fifo_data(w_rdata),
      .o_fifo_valid(w_valid), .o_fifo_empty(w_empty), .i_fifo_we(w_we), .i_fifo_data(w_wdata),
      .o_fifo_full(w_full), .o_fifo_count(w_count), .o_fifo_afull(w_afull), .o_fifo_aempty(w_aempty),
      .o_fifo_overflow(w_ovf), .o_fifo_underflow(w_udf));

   wire [6:0] s_stat = {s_empty, s_full, s_afull, s_aempty, s_valid, s_ovf, s_udf};
   wire [6:0] f_stat = {f_empty, f_full, f_afull, f_aempty, f_valid, f_ovf, f_udf};
   wire [6:0] w_stat = {w_empty, w_full, w_afull, w_aempty, w_valid, w_ovf, w_udf};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic s_push4(input logic [7:0] base);
      for (int i = 0; i < 4; i++) begin
         s_we = 1'b1;
         s_wdata = base + 8'(i);
         tick();
      end
      s_we = 1'b0;
   endtask

   task automatic s_flush1();
      s_flush = 1'b1;
      tick();
      s_flush = 1'b0;
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      #2;
      checks++; if (s_stat !== 7'b1001000) begin errors++; $display("FAIL reset_std_status: got %b expected %b", s_stat, 7'b1001000); end
      checks++; if (s_count !== 3'd0) begin errors++; $display("FAIL reset_std_count: got %0d expected 0", s_count); end
      checks++; if (s_rdata !== 8'h00) begin errors++; $display("FAIL reset_std_data: got %h expected 00", s_rdata); end
      checks++; if (f_stat !== 7'b1001000) begin errors++; $display("FAIL reset_fwft_status: got %b expected %b", f_stat, 7'b1001000); end
      checks++; if (w_stat !== 7'b1001000) begin errors++; $display("FAIL reset_wrap_status: got %b expected %b", w_stat, 7'b1001000); end
      #1 n_rst = 1'b1;
      tick();
   endtask

   task automatic test_std_fill();
      s_push4(8'hA1);
      checks++; if (s_count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d expected 4", s_count); end
      checks++; if (s_stat !== 7'b0110000) begin errors++; $display("FAIL fill_status: got %b expected %b", s_stat, 7'b0110000); end
      s_ack = 1'b1;
      tick();
      s_ack = 1'b0;
      checks++; if (s_rdata !== 8'hA1) begin errors++; $display("FAIL pop1_data: got %h expected a1", s_rdata); end
      checks++; if (s_count !== 3'd3) begin errors++; $display("FAIL pop1_count: got %0d expected 3", s_count); end
      checks++; if (s_stat !== 7'b0010100) begin errors++; $display("FAIL pop1_status: got %b expected %b", s_stat, 7'b0010100); end
      tick();
      checks++; if ({s_valid, s_rdata} !== {1'b0, 8'hA1}) begin errors++; $display("FAIL pop1_hold: got %b/%h expected 0/a1", s_valid, s_rdata); end
   endtask

   task automatic test_push_while_full();
      logic [7:0] exp_drain [4] = '{8'hA2, 8'hA3, 8'hA4, 8'hB5};
      s_flush1();
      checks++; if (s_stat !== 7'b1001000) begin errors++; $display("FAIL flush_status: got %b expected %b", s_stat, 7'b1001000); end
      checks++; if (s_rdata !== 8'hA1) begin errors++; $display("FAIL flush_data_hold: got %h expected a1", s_rdata); end
      s_push4(8'hA1);
      s_we = 1'b1; s_wdata = 8'hB5; s_ack = 1'b1;
      tick();
      s_we = 1'b0; s_ack = 1'b0;
      checks++; if (s_rdata !== 8'hA1) begin errors++; $display("FAIL pwf_data: got %h expected a1", s_rdata); end
      checks++; if (s_count !== 3'd4) begin errors++; $display("FAIL pwf_count: got %0d expected 4", s_count); end
      checks++; if (s_stat !== 7'b0110100) begin errors++; $display("FAIL pwf_status: got %b expected %b", s_stat, 7'b0110100); end
      for (int i = 0; i < 4; i++) begin
         s_ack = 1'b1;
         tick();
         checks++; if ({s_valid, s_rdata} !== {1'b1, exp_drain[i]}) begin errors++; $display("FAIL pwf_drain%0d: got %b/%h expected 1/%h", i, s_valid, s_rdata, exp_drain[i]); end
      end
      s_ack = 1'b0;
      checks++; if (s_count !== 3'd0) begin errors++; $display("FAIL pwf_drained_count: got %0d expected 0", s_count); end
      checks++; if (s_stat !== 7'b1001100) begin errors++; $display("FAIL pwf_drained_status: got %b expected %b", s_stat, 7'b1001100); end
   endtask

   task automatic test_errors();
      s_we = 1'b1; s_wdata = 8'hE7; s_ack = 1'b1;
      tick();
      s_we = 1'b0; s_ack = 1'b0;
      checks++; if (s_count !== 3'd1) begin errors++; $display("FAIL pwe_count: got %0d expected 1", s_count); end
      checks++; if (s_stat !== 7'b0001001) begin errors++; $display("FAIL pwe_status: got %b expected %b", s_stat, 7'b0001001); end
      s_ack = 1'b1;
      tick();
      s_ack = 1'b0;
      checks++; if ({s_valid, s_rdata} !== {1'b1, 8'hE7}) begin errors++; $display("FAIL pwe_pop: got %b/%h expected 1/e7", s_valid, s_rdata); end
      s_flush1();
      checks++; if ({s_ovf, s_udf} !== 2'b00) begin errors++; $display("FAIL pwe_flush_flags: got %b expected 00", {s_ovf, s_udf}); end
      s_push4(8'hC1);
      s_we = 1'b1; s_wdata = 8'hDD;
      tick();
      s_we = 1'b0;
      checks++; if ({s_ovf, s_udf} !== 2'b10) begin errors++; $display("FAIL ovf_flags: got %b expected 10", {s_ovf, s_udf}); end
      checks++; if (s_count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d expected 4", s_count); end
      for (int i = 0; i < 4; i++) begin
         s_ack = 1'b1;
         tick();
         checks++; if (s_rdata !== 8'hC1 + 8'(i)) begin errors++; $display("FAIL ovf_contents%0d: got %h expected %h", i, s_rdata, 8'hC1 + 8'(i)); end
      end
      tick();
      s_ack = 1'b0;
      checks++; if ({s_valid, s_ovf, s_udf} !== 3'b011) begin errors++; $display("FAIL udf_flags: got %b expected 011", {s_valid, s_ovf, s_udf}); end
      s_flush = 1'b1; s_we = 1'b1; s_ack = 1'b1; s_wdata = 8'h5A;
      tick();
      s_flush = 1'b0; s_we = 1'b0; s_ack = 1'b0;
      checks++; if (s_stat !== 7'b1001000) begin errors++; $display("FAIL flush_prio_status: got %b expected %b", s_stat, 7'b1001000); end
   endtask

   task automatic test_fwft();
      f_we = 1'b1; f_wdata = 8'h33;
      #1;
      checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL fwft_no_comb: got %b expected 0", f_valid); end
      tick();
      f_we = 1'b0;
      checks++; if ({f_valid, f_rdata} !== {1'b1, 8'h33}) begin errors++; $display("FAIL fwft_show: got %b/%h expected 1/33", f_valid, f_rdata); end
      checks++; if (f_stat !== 7'b0001100) begin errors++; $display("FAIL fwft_status: got %b expected %b", f_stat, 7'b0001100); end
      f_ack = 1'b1;
      tick();
      f_ack = 1'b0;
      checks++; if ({f_empty, f_valid} !== 2'b10) begin errors++; $display("FAIL fwft_pop: got %b expected 10", {f_empty, f_valid}); end
      f_we = 1'b1; f_wdata = 8'h44;
      tick();
      f_wdata = 8'h55;
      tick();
      f_we = 1'b0;
      checks++; if ({f_count, f_rdata} !== {3'd2, 8'h44}) begin errors++; $display("FAIL fwft_head: got %0d/%h expected 2/44", f_count, f_rdata); end
      f_ack = 1'b1;
      tick();
      checks++; if ({f_valid, f_rdata} !== {1'b1, 8'h55}) begin errors++; $display("FAIL fwft_next: got %b/%h expected 1/55", f_valid, f_rdata); end
      tick();
      f_ack = 1'b0;
      checks++; if (f_stat !== 7'b1001000) begin errors++; $display("FAIL fwft_drained: got %b expected %b", f_stat, 7'b1001000); end
   endtask

   task automatic test_wrap();
      w_we = 1'b1; w_wdata = 8'd0;
      tick();
      for (int k = 1; k < 7; k++) begin
         w_wdata = 8'(k); w_ack = 1'b1;
         tick();
         checks++; if ({w_valid, w_rdata, w_count} !== {1'b1, 8'(k-1), 2'd1}) begin errors++; $display("FAIL wrap%0d: got %b/%h/%0d expected 1/%h/1", k, w_valid, w_rdata, w_count, 8'(k-1)); end
      end
      w_we = 1'b0;
      tick();
      w_ack = 1'b0;
      checks++; if ({w_rdata, w_count} !== {8'd6, 2'd0}) begin errors++; $display("FAIL wrap_last: got %h/%0d expected 06/0", w_rdata, w_count); end
      checks++; if ({w_ovf, w_udf, w_empty} !== 3'b001) begin errors++; $display("FAIL wrap_flags: got %b expected 001", {w_ovf, w_udf, w_empty}); end
   endtask

   task automatic test_reset_midop();
      for (int i = 0; i < 3; i++) begin
         s_we = 1'b1; s_wdata = 8'h11 * 8'(i + 1);
         tick();
      end
      s_we = 1'b0; s_ack = 1'b1;
      tick();
      s_ack = 1'b0;
      checks++; if ({s_count, s_valid, s_rdata} !== {3'd2, 1'b1, 8'h11}) begin errors++; $display("FAIL midop_pre: got %0d/%b/%h expected 2/1/11", s_count, s_valid, s_rdata); end
      #2 n_rst = 1'b0;
      #1;
      checks++; if ({s_empty, s_count, s_valid, s_rdata} !== {1'b1, 3'd0, 1'b0, 8'h00}) begin errors++; $display("FAIL midop_async: got %b/%0d/%b/%h expected 1/0/0/00", s_empty, s_count, s_valid, s_rdata); end
      #2 n_rst = 1'b1;
      tick();
      s_we = 1'b1; s_wdata = 8'h44;
      tick();
      s_flush = 1'b1; s_wdata = 8'h55;
      tick();
      s_flush = 1'b0; s_we = 1'b0;
      checks++; if ({s_empty, s_count, s_ovf} !== {1'b1, 3'd0, 1'b0}) begin errors++; $display("FAIL flush_push: got %b/%0d/%b expected 1/0/0", s_empty, s_count, s_ovf); end
   endtask

   initial begin
      test_reset();
      test_std_fill();
      test_push_while_full();
      test_errors();
      test_fwft();
      test_wrap();
      test_reset_midop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
